mem_byte_ctrl: RTL and testbench

//  CPU-side initiator of the byte-serial memory bus: mem_a/mem_wr/mem_dout out, mem_din in.

---
 rtl/mem_byte_ctrl_pkg.sv | 34 +++
 rtl/mem_byte_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory bus initiator.
// Holds state encoding, access size codes and load extension.
package mem_byte_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIfRd,
        StLsRd,
        StLsWr
    } state_e;

    localparam logic [1:0] SzB = 2'd0;
    localparam logic [1:0] SzH = 2'd1;
    localparam logic [1:0] SzW = 2'd2;

    // Size code 3 is illegal and behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SzB:     return 3'd1;
            SzH:     return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] word);
        case (size)
            SzB:     return {{24{sgn & word[7]}}, word[7:0]};
            SzH:     return {{16{sgn & word[15]}}, word[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_ctrl.sv
// CPU-side initiator of the byte-serial memory bus: splits fetches and LSU accesses into
// per-byte RAM/IO cycles with stall handling for host ownership and a full UART buffer.
module mem_byte_ctrl
    import mem_byte_ctrl_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        busy
);

    state_e      st_q, st_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  issue_q, issue_d;
    logic [2:0]  cap_q, cap_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        fresh_q, fresh_d;
    logic        dvalid_q, dvalid_d;
    logic        rdy_q;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        accept, run, resume, retire, finish, want, blocked, issue;
    state_e      new_st, op_st;
    logic [31:0] op_base, op_wdata, byte_addr, asm_nx;
    logic [2:0]  op_n, idx;
    logic [7:0]  wbyte;

    // Shared issue path: on acceptance the first byte goes out from the request itself.
    always_comb begin
        accept = (st_q == StIdle) && rdy_in && (ls_req || (if_req && !if_cancel));
        run    = (st_q != StIdle) && rdy_in;
        resume = run && !rdy_q;
        if (ls_req) begin
            new_st = ls_we ? StLsWr : StLsRd;
        end else begin
            new_st = StIfRd;
        end
        op_st    = accept ? new_st : st_q;
        op_base  = accept ? (ls_req ? ls_addr : if_addr) : addr_q;
        op_wdata = accept ? ls_wdata : wdata_q;
        op_n     = accept ? (ls_req ? size_bytes(ls_size) : 3'd4) : n_q;
        // After a host stall the bus pipeline is stale: restart from the oldest uncaptured byte.
        idx       = accept ? 3'd0 : (resume ? cap_q : issue_q);
        retire    = run && !resume && ((st_q == StLsWr) ? mem_wr_q : dvalid_q);
        finish    = retire && ((cap_q + 3'd1) == n_q);
        byte_addr = op_base + {29'd0, idx};
        wbyte     = 8'(op_wdata >> {idx[1:0], 3'b000});
        want      = (accept || run) && !finish && (idx < op_n);
        blocked   = (op_st == StLsWr) && io_buffer_full &&
                    (byte_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
        issue     = want && !blocked;
        asm_nx    = asm_q;
        case (cap_q[1:0])
            2'd0:    asm_nx[7:0]   = mem_din;
            2'd1:    asm_nx[15:8]  = mem_din;
            2'd2:    asm_nx[23:16] = mem_din;
            default: asm_nx[31:24] = mem_din;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        n_d        = n_q;
        issue_d    = issue_q;
        cap_d      = cap_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        fresh_d    = fresh_q;
        dvalid_d   = dvalid_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;

        if (st_q == StIdle) begin
            mem_wr_d = 1'b0;
        end
        if (accept) begin
            st_d    = new_st;
            addr_d  = op_base;
            wdata_d = op_wdata;
            n_d     = op_n;
            size_d  = ls_size;
            sgn_d   = ls_signed;
            cap_d   = 3'd0;
            asm_d   = 32'd0;
        end
        if (accept || run) begin
            mem_wr_d = 1'b0;
            fresh_d  = 1'b0;
            dvalid_d = run && !resume && fresh_q;
            issue_d  = idx + {2'd0, issue};
            if (retire) begin
                cap_d = cap_q + 3'd1;
                asm_d = asm_nx;
            end
            if (issue) begin
                mem_a_d = byte_addr;
                if (op_st == StLsWr) begin
                    mem_dout_d = wbyte;
                    mem_wr_d   = 1'b1;
                end else begin
                    fresh_d = 1'b1;
                end
            end
            if (finish) begin
                st_d = StIdle;
                case (st_q)
                    StIfRd: begin
                        if_done_d = 1'b1;
                        if_data_d = asm_nx;
                    end
                    StLsRd: begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = load_ext(size_q, sgn_q, asm_nx);
                    end
                    default: begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = 32'd0;
                    end
                endcase
            end
        end
        // A cancelled fetch leaves the address bus untouched so no new location is read.
        if ((st_q == StIfRd) && if_cancel) begin
            st_d      = StIdle;
            mem_a_d   = mem_a_q;
            fresh_d   = 1'b0;
            dvalid_d  = 1'b0;
            mem_wr_d  = 1'b0;
            if_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            st_q       <= StIdle;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
            n_q        <= 3'd0;
            issue_q    <= 3'd0;
            cap_q      <= 3'd0;
            size_q     <= SzW;
            sgn_q      <= 1'b0;
            fresh_q    <= 1'b0;
            dvalid_q   <= 1'b0;
            rdy_q      <= 1'b1;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            n_q        <= n_d;
            issue_q    <= issue_d;
            cap_q      <= cap_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            fresh_q    <= fresh_d;
            dvalid_q   <= dvalid_d;
            rdy_q      <= rdy_in;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // While the host owns the bus no write strobe may escape, even one already registered.
    assign mem_wr   = mem_wr_q & rdy_in;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    assign busy     = (st_q != StIdle);

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Bench for mem_byte_ctrl: registered-read RAM/IO responder, directed bus-timing steps and
// random traffic checked against a byte-array reference of memory.
module tb_mem_byte_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_cancel, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_we, ls_signed, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram     [65536];
    logic [7:0]  ref_mem [65536];
    logic        ram_init;
    int          io_wr_cnt = 0;
    int          io_bad = 0;

    bit          rdy_pat [64];
    bit          full_pat [64];
    bit          rst_pat [64];
    bit          cancel_pat [64];
    logic [31:0] bus_a [64];
    logic        bus_wr [64];
    logic [7:0]  bus_do [64];
    logic        bus_busy [64];

    mem_byte_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel), .if_done(if_done),
        .if_data(if_data), .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit tb_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [7:0] init_byte(input int unsigned i);
        case (i)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            32'h2002: return 8'h7F;
            32'h2003: return 8'h80;
            default:  return 8'((i * 97) ^ (i >> 7));
        endcase
    endfunction

    // Responder: data for the address seen in one cycle appears on mem_din the next cycle.
    always @(posedge clk_in) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
        end else begin
            if (!rdy_in) mem_din <= 8'($urandom);
            else if (tb_io(mem_a)) mem_din <= 8'h00;
            else mem_din <= ram[mem_a[15:0]];
            if (mem_wr) begin
                if (tb_io(mem_a)) begin
                    io_wr_cnt <= io_wr_cnt + 1;
                    if (io_buffer_full) io_bad <= io_bad + 1;
                end else begin
                    ram[mem_a[15:0]] <= mem_dout;
                end
            end
        end
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai = a + 32'(i);
            v = v | (32'(ref_mem[ai[15:0]]) << (8 * i));
        end
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai = a + 32'(i);
            ref_mem[ai[15:0]] = 8'(d >> (8 * i));
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pats();
        for (int k = 0; k < 64; k++) begin
            rdy_pat[k] = 1'b1; full_pat[k] = 1'b0; rst_pat[k] = 1'b0; cancel_pat[k] = 1'b0;
        end
    endtask

    task automatic apply_pats(input int k);
        rdy_in = rdy_pat[k]; io_buffer_full = full_pat[k];
        rst_in = rst_pat[k]; if_cancel = cancel_pat[k];
    endtask

    // Request in cycle 0, then record the bus each cycle until the done pulse or the limit.
    task automatic run_op(input bit is_if, input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int limit,
                          output logic [31:0] res, output int lat);
        @(posedge clk_in); #1;
        apply_pats(0);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = size; ls_signed = sgn;
            ls_addr = addr; ls_wdata = wdata;
        end
        lat = -1;
        res = 32'd0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk_in); #1;
            if_req = 1'b0; ls_req = 1'b0;
            apply_pats(k);
            bus_a[k] = mem_a; bus_wr[k] = mem_wr; bus_do[k] = mem_dout; bus_busy[k] = busy;
            if (is_if ? if_done : ls_done) begin
                lat = k;
                res = is_if ? if_data : ls_rdata;
                break;
            end
        end
        clear_pats();
        apply_pats(0);
    endtask

    initial begin
        logic [31:0] res, exp, a7, lsd, ifd;
        int lat, ls_lat, if_lat, io_before, n, kind, diffs;
        logic [31:0] addr, wd;
        logic [1:0] size;
        bit sgn;

        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; ram_init = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; if_cancel = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
        ls_addr = 32'd0; ls_wdata = 32'd0;
        clear_pats();
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(posedge clk_in);
        #1 ram_init = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_ls_done", 32'(ls_done), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Word fetch timing and little-endian assembly.
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 20, res, lat);
        for (int k = 1; k <= 4; k++) check($sformatf("fetch_a%0d", k), bus_a[k], 32'h1000 + k - 1);
        check("fetch_lat", lat, 6);
        check("fetch_data", res, 32'h0000_0513);

        run_op(1'b0, 1'b0, 2'd0, 1'b1, 32'h2003, 32'd0, 20, res, lat);
        check("lb_data", res, 32'hFFFF_FF80);
        check("lb_lat", lat, 3);
        run_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h2003, 32'd0, 20, res, lat);
        check("lbu_data", res, 32'h0000_0080);
        run_op(1'b0, 1'b0, 2'd1, 1'b1, 32'h2002, 32'd0, 20, res, lat);
        check("lh_data", res, 32'hFFFF_807F);
        check("lh_lat", lat, 4);

        // Word store byte order and timing.
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h2000, 32'hDEAD_BEEF, 20, res, lat);
        ref_store(32'h2000, 4, 32'hDEAD_BEEF);
        check("sw_wr", {28'd0, bus_wr[1], bus_wr[2], bus_wr[3], bus_wr[4]}, 32'hF);
        check("sw_bytes", {bus_do[1], bus_do[2], bus_do[3], bus_do[4]}, 32'hEFBE_ADDE);
        check("sw_lat", lat, 5);
        check("sw_rdata", res, 32'd0);
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 20, res, lat);
        check("sw_readback", res, 32'hDEAD_BEEF);

        // IO byte store held off while the UART buffer is full.
        for (int k = 0; k <= 3; k++) full_pat[k] = 1'b1;
        io_before = io_wr_cnt;
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h41, 20, res, lat);
        check("io_nowr", {28'd0, bus_wr[1], bus_wr[2], bus_wr[3], bus_wr[4]}, 32'd0);
        check("io_wr5", 32'(bus_wr[5]), 32'd1);
        check("io_a5", bus_a[5], 32'h0003_0000);
        check("io_do5", 32'(bus_do[5]), 32'h41);
        check("io_wr6", 32'(bus_wr[6]), 32'd0);
        check("io_lat", lat, 6);
        check("io_count", io_wr_cnt - io_before, 1);
        check("io_full_wr", io_bad, 0);

        // Simultaneous requests: load first, fetch accepted in the load's done cycle.
        @(posedge clk_in); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_signed = 1'b0; ls_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h1000;
        ls_lat = -1; if_lat = -1; a7 = 32'd0; lsd = 32'd0; ifd = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            ls_req = 1'b0;
            if (k == 7) begin
                if_req = 1'b0;
                a7 = mem_a;
            end
            if (ls_done && ls_lat < 0) begin ls_lat = k; lsd = ls_rdata; end
            if (if_done && if_lat < 0) begin if_lat = k; ifd = if_data; end
        end
        check("tie_ls_lat", ls_lat, 6);
        check("tie_ls_data", lsd, ref_load(32'h2000, 4, 1'b0));
        check("tie_if_a", a7, 32'h1000);
        check("tie_if_lat", if_lat, 12);
        check("tie_if_data", ifd, ref_load(32'h1000, 4, 1'b0));

        // Fetch cancelled in cycle 2.
        cancel_pat[2] = 1'b1;
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 10, res, lat);
        check("cancel_nodone", lat, -1);
        check("cancel_busy2", 32'(bus_busy[2]), 32'd1);
        check("cancel_idle3", 32'(bus_busy[3]), 32'd0);

        // Host takes the bus in cycles 2-3 of a word load.
        rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0;
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 30, res, lat);
        check("stall_data", res, ref_load(32'h1000, 4, 1'b0));
        check("stall_delayed", 32'(lat > 6), 32'd1);

        // Reset in cycle 2 of a word store: two bytes land, no done.
        rst_pat[2] = 1'b1;
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h4000, 32'h1122_3344, 8, res, lat);
        ref_store(32'h4000, 2, 32'h1122_3344);
        check("rst_st_wr2", 32'(bus_wr[2]), 32'd1);
        check("rst_st_wr3", 32'(bus_wr[3]), 32'd0);
        check("rst_st_busy3", 32'(bus_busy[3]), 32'd0);
        check("rst_st_nodone", lat, -1);

        // Random RAM traffic against the reference byte array.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 32'hFFF0));
            wd   = $urandom;
            size = (kind == 1 || kind == 2 || kind == 6) ? 2'd0 :
                   (kind == 3 || kind == 4 || kind == 7) ? 2'd1 :
                   (kind == 9) ? 2'd3 : 2'd2;
            sgn  = (kind == 1 || kind == 3);
            n    = (kind == 0) ? 4 : nbytes(size);
            if (kind == 0) begin
                run_op(1'b1, 1'b0, 2'd2, 1'b0, addr, 32'd0, 20, res, lat);
                exp = ref_load(addr, 4, 1'b0);
            end else if (kind >= 6 && kind <= 8) begin
                run_op(1'b0, 1'b1, size, 1'b0, addr, wd, 20, res, lat);
                ref_store(addr, n, wd);
                exp = 32'd0;
            end else begin
                run_op(1'b0, 1'b0, size, sgn, addr, 32'd0, 20, res, lat);
                exp = ref_load(addr, n, sgn);
            end
            check($sformatf("rnd%0d_k%0d_data", i, kind), res, exp);
            check($sformatf("rnd%0d_k%0d_lat", i, kind), lat,
                  (kind >= 6 && kind <= 8) ? n + 1 : n + 2);
        end

        diffs = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check("ram_image", diffs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
